// File: rtl/serial_subtractor_pkg.sv
// -----------------------------------------------------------------------------
// serial_subtractor_pkg
// Shared definitions for the bit-serial arithmetic blocks.
// The control state encoding is common to every serial arithmetic unit, so that
// a controlling FSM can decode any of them the same way.
// -----------------------------------------------------------------------------
package serial_subtractor_pkg;

    // Control states of a serial arithmetic unit
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage : serial_subtractor_pkg

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and operand/result bundle of the bit-serial subtractor.
//   start      : request, accepted only while busy==0
//   a, b       : minuend / subtrahend, sampled on the accepting edge
//   busy       : high while the subtraction is shifting
//   done       : one-cycle pulse, results valid from this cycle
//   diff       : (a - b) mod 2^WIDTH
//   borrow_out : 1 iff a < b (unsigned)
// Modports: master = controller side, slave = subtractor side.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow_out
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow_out
    );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_full_sub_cell.sv
// -----------------------------------------------------------------------------
// full_sub_cell
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow.
// Built from two half-subtractor stages; the two stage borrows are ORed
// (they can never both be 1).
// Ports:
//   i_a, i_b, i_bin : minuend bit, subtrahend bit, borrow in
//   o_d, o_bout     : difference bit, borrow out
// -----------------------------------------------------------------------------
module full_sub_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);
    logic w_d1;
    logic w_b1;
    logic w_b2;

    // First half subtractor: a - b
    assign w_d1 = i_a ^ i_b;
    assign w_b1 = ~i_a & i_b;

    // Second half subtractor: (a - b) - bin
    assign o_d  = w_d1 ^ i_bin;
    assign w_b2 = ~w_d1 & i_bin;

    assign o_bout = w_b1 | w_b2;
endmodule : full_sub_cell

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial unsigned subtractor, diff = a - b, LSB first, one bit per clock.
// Accept-to-done is WIDTH+1 rising edges; results are registered and hold
// until the next done pulse.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset; aborts an operation without done
//   bus   : serial_subtractor_if.slave (start/a/b in, busy/done/diff/borrow_out out)
// -----------------------------------------------------------------------------
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    serial_subtractor_if.slave  bus
);
    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;
    logic             r_bw;
    logic [CNT_W-1:0] r_cnt;

    logic             w_d;
    logic             w_bout;
    logic             w_accept;

    full_sub_cell u_cell (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_bin  (r_bw),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    // A request is taken in IDLE and also in DONE, which gives back-to-back issue
    assign w_accept = bus.start & ((r_state == ST_IDLE) | (r_state == ST_DONE));

    // Control FSM, serial datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_d_sr       <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
            r_bw         <= 1'b0;
            r_cnt        <= '0;
        end else if (w_accept) begin
            r_state <= ST_SHIFT;
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_d_sr  <= '0;
            r_bw    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_d_sr <= {w_d, r_d_sr[WIDTH-1:1]};
                    r_bw   <= w_bout;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    // Last bit: capture the fully assembled result directly,
                    // including the bit being produced on this edge
                    if (r_cnt == CNT_LAST) begin
                        r_state      <= ST_DONE;
                        r_diff       <= {w_d, r_d_sr[WIDTH-1:1]};
                        r_borrow_out <= w_bout;
                    end else begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_IDLE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy       = (r_state == ST_SHIFT);
    assign bus.done       = (r_state == ST_DONE);
    assign bus.diff       = r_diff;
    assign bus.borrow_out = r_borrow_out;

endmodule : serial_subtractor
